// File: rtl/gfx_rom_sched.sv
// Arbitrates one shared GFX ROM port between queued render line fetches and CPU byte reads.
// Optional SCHED_STATS_EN adds stat_maxwait, the worst CPU request-to-ack latency seen since reset.
module gfx_rom_sched #(
  parameter int AW           = 21,
  parameter int DW           = 32,
  parameter int CPU_MAX_WAIT = 4,
  parameter int RQ_DEPTH     = 2
) (
  input  logic          clk_24M,
  input  logic          nRES,
  input  logic          rnd_req,
  input  logic [1:0]    rnd_layer,
  input  logic [AW-1:0] rnd_addr,
  input  logic          cpu_req,
  input  logic [AW+1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [7:0]    cpu_data,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] fix_data,
  output logic [DW-1:0] a_data,
  output logic [DW-1:0] b_data,
  output logic [2:0]    data_vld,
  output logic          ovf
`ifdef SCHED_STATS_EN
  ,
  output logic [7:0]    stat_maxwait
`endif
);

  localparam int PW  = $clog2(RQ_DEPTH);
  localparam int WCW = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [PW:0]    DEPTH_C  = (PW+1)'(RQ_DEPTH);
  localparam logic [PW:0]    CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
  localparam logic [WCW-1:0] MAXW     = WCW'(CPU_MAX_WAIT);
  localparam logic [WCW-1:0] WAIT_ONE = WCW'(1);

  typedef enum logic [1:0] {IDLE, RND, CPU} state_t;

  state_t          state_q, state_d;
  logic [AW+1:0]   fifo_mem [RQ_DEPTH];
  logic [PW-1:0]   rd_q, wr_q;
  logic [PW:0]     cnt_q, cnt_d;
  logic [AW+1:0]   head;
  logic            fifo_empty, fifo_full, push_req, push_ok, pop;
  logic            cpu_grant;
  logic [WCW-1:0]  waitcnt_q, waitcnt_d;
  logic            served_q, served_d;
  logic [1:0]      layer_q, layer_d, lane_q, lane_d;
  logic            mem_req_q, mem_req_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic [7:0]      cpu_data_q, cpu_data_d;
  logic [DW-1:0]   fix_q, fix_d, a_q, a_d, b_q, b_d;
  logic [2:0]      vld_q, vld_d;
  logic            ovf_q, ovf_d;

  assign head       = fifo_mem[rd_q];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_C);
  // Layer 3 is not a real plane; such requests never enter the queue.
  assign push_req   = rnd_req && (rnd_layer != 2'd3);
  assign push_ok    = push_req && (!fifo_full || pop);
  assign cpu_grant  = cpu_req && !served_q && (fifo_empty || (waitcnt_q == MAXW));

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!push_ok && pop) cnt_d = cnt_q - CNT_ONE;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    waitcnt_d  = waitcnt_q;
    served_d   = cpu_req ? served_q : 1'b0;
    layer_d    = layer_q;
    lane_d     = lane_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    cpu_ack_d  = 1'b0;
    cpu_data_d = cpu_data_q;
    fix_d      = fix_q;
    a_d        = a_q;
    b_d        = b_q;
    vld_d      = 3'b000;
    ovf_d      = ovf_q | (push_req && fifo_full && !pop);
    case (state_q)
      IDLE: begin
        if (cpu_grant) begin
          state_d    = CPU;
          mem_req_d  = 1'b1;
          mem_addr_d = cpu_addr[AW+1:2];
          lane_d     = cpu_addr[1:0];
        end else if (!fifo_empty) begin
          state_d    = RND;
          pop        = 1'b1;
          mem_req_d  = 1'b1;
          mem_addr_d = head[AW-1:0];
          layer_d    = head[AW+1:AW];
          if (cpu_req && !served_q && (waitcnt_q != MAXW)) waitcnt_d = waitcnt_q + WAIT_ONE;
        end
      end
      RND: begin
        if (mem_ack) begin
          case (layer_q)
            2'd0:    begin fix_d = mem_data; vld_d = 3'b001; end
            2'd1:    begin a_d   = mem_data; vld_d = 3'b010; end
            default: begin b_d   = mem_data; vld_d = 3'b100; end
          endcase
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      CPU: begin
        if (mem_ack) begin
          case (lane_q)
            2'd0:    cpu_data_d = mem_data[7:0];
            2'd1:    cpu_data_d = mem_data[15:8];
            2'd2:    cpu_data_d = mem_data[23:16];
            default: cpu_data_d = mem_data[31:24];
          endcase
          cpu_ack_d = 1'b1;
          served_d  = 1'b1;
          waitcnt_d = '0;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_24M) begin
    if (push_ok) fifo_mem[wr_q] <= {rnd_layer, rnd_addr};
  end

  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      waitcnt_q  <= '0;
      served_q   <= 1'b0;
      layer_q    <= 2'd0;
      lane_q     <= 2'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      cpu_ack_q  <= 1'b0;
      cpu_data_q <= 8'h00;
      fix_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      vld_q      <= 3'b000;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (pop)     rd_q <= rd_q + PTR_ONE;
      if (push_ok) wr_q <= wr_q + PTR_ONE;
      cnt_q      <= cnt_d;
      waitcnt_q  <= waitcnt_d;
      served_q   <= served_d;
      layer_q    <= layer_d;
      lane_q     <= lane_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cpu_ack_q  <= cpu_ack_d;
      cpu_data_q <= cpu_data_d;
      fix_q      <= fix_d;
      a_q        <= a_d;
      b_q        <= b_d;
      vld_q      <= vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign cpu_ack  = cpu_ack_q;
  assign cpu_data = cpu_data_q;
  assign fix_data = fix_q;
  assign a_data   = a_q;
  assign b_data   = b_q;
  assign data_vld = vld_q;
  assign ovf      = ovf_q;

`ifdef SCHED_STATS_EN
  logic       req_prev_q, track_q;
  logic [7:0] wcnt_q, max_q;

  // Counts from the cycle cpu_req rises until its ack is visible.
  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      req_prev_q <= 1'b0;
      track_q    <= 1'b0;
      wcnt_q     <= 8'h00;
      max_q      <= 8'h00;
    end else begin
      req_prev_q <= cpu_req;
      if (cpu_req && !req_prev_q) begin
        track_q <= 1'b1;
        wcnt_q  <= 8'h00;
      end else if (track_q && (wcnt_q != 8'hFF)) begin
        wcnt_q  <= wcnt_q + 8'h01;
      end
      if (cpu_ack_q && track_q) begin
        track_q <= 1'b0;
        if (wcnt_q > max_q) max_q <= wcnt_q;
      end
    end
  end

  assign stat_maxwait = max_q;
`endif

endmodule

// File: tb/tb_gfx_rom_sched.sv
// Directed bench for gfx_rom_sched: render/CPU arbitration, starvation bound, overflow, reset.
module tb_gfx_rom_sched;
  localparam int AW = 21;
  localparam int DW = 32;

  logic          clk_24M = 1'b0;
  logic          nRES = 1'b0;
  logic          rnd_req = 1'b0;
  logic [1:0]    rnd_layer = 2'd0;
  logic [AW-1:0] rnd_addr = '0;
  logic          cpu_req = 1'b0;
  logic [AW+1:0] cpu_addr = '0;
  logic          cpu_ack;
  logic [7:0]    cpu_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] fix_data, a_data, b_data;
  logic [2:0]    data_vld;
  logic          ovf;
`ifdef SCHED_STATS_EN
  logic [7:0]    stat_maxwait;
`endif

  int errors = 0;
  int checks = 0;

  gfx_rom_sched dut (
    .clk_24M  (clk_24M),
    .nRES     (nRES),
    .rnd_req  (rnd_req),
    .rnd_layer(rnd_layer),
    .rnd_addr (rnd_addr),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_ack  (cpu_ack),
    .cpu_data (cpu_data),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .fix_data (fix_data),
    .a_data   (a_data),
    .b_data   (b_data),
    .data_vld (data_vld),
    .ovf      (ovf)
`ifdef SCHED_STATS_EN
    ,
    .stat_maxwait(stat_maxwait)
`endif
  );

  always #5 clk_24M = ~clk_24M;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_24M);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(mem_req), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants, acks, ri, next_push;
    logic [AW-1:0] exp_addr [9];
    logic          is_cpu;

    // Reset state
    repeat (3) tick();
    chk("rst_mem_req",  64'(mem_req),  64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_cpu_ack",  64'(cpu_ack),  64'd0);
    chk("rst_cpu_data", 64'(cpu_data), 64'd0);
    chk("rst_a_data",   64'(a_data),   64'd0);
    chk("rst_data_vld", 64'(data_vld), 64'd0);
    chk("rst_ovf",      64'(ovf),      64'd0);
    nRES = 1'b1;
    tick();

    // Single render fetch on layer A
    rnd_req = 1'b1; rnd_layer = 2'd1; rnd_addr = 21'h00123;
    tick();
    rnd_req = 1'b0;
    chk("r1_lat_lo", 64'(mem_req), 64'd0);
    tick();
    chk("r1_lat_hi", 64'(mem_req), 64'd1);
    chk("r1_addr", 64'(mem_addr), 64'h123);
    repeat (2) tick();
    mem_ack = 1'b1; mem_data = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    chk("r1_a_data", 64'(a_data), 64'hDEADBEEF);
    chk("r1_vld", 64'(data_vld), 64'b010);
    chk("r1_fix_untouched", 64'(fix_data), 64'd0);
    chk("r1_req_drop", 64'(mem_req), 64'd0);
    tick();
    chk("r1_vld_pulse", 64'(data_vld), 64'd0);
    chk("r1_ovf", 64'(ovf), 64'd0);

    // CPU byte read, lane 2
    cpu_addr = 23'h000406; cpu_req = 1'b1;
    tick();
    chk("c1_req", 64'(mem_req), 64'd1);
    chk("c1_addr", 64'(mem_addr), 64'h101);
    tick();
    mem_ack = 1'b1; mem_data = 32'h44332211;
    tick();
    mem_ack = 1'b0;
    chk("c1_ack", 64'(cpu_ack), 64'd1);
    chk("c1_data", 64'(cpu_data), 64'h33);
    grants = 0; acks = 0;
    repeat (6) begin
      tick();
      if (mem_req) grants++;
      if (cpu_ack) acks++;
    end
    chk("c1_no_regrant", 64'(grants), 64'd0);
    chk("c1_single_ack", 64'(acks), 64'd0);
    chk("c1_data_held", 64'(cpu_data), 64'h33);
    cpu_req = 1'b0;
    tick();

    // Starvation bound: four render grants, then the CPU, then renders again
    exp_addr = '{21'h200, 21'h201, 21'h202, 21'h203, 21'h204, 21'hFFFFD, 21'h205, 21'h206, 21'h207};
    cpu_addr = 23'h3FFFF5;
    rnd_req = 1'b1; rnd_layer = 2'd0; rnd_addr = 21'h200;
    tick();
    rnd_layer = 2'd1; rnd_addr = 21'h201;
    tick();
    rnd_req = 1'b0;
    cpu_req = 1'b1;
    next_push = 2;
    for (int t = 0; t < 9; t++) begin
      is_cpu = (t == 5);
      ri = (t < 5) ? t : t - 1;
      wait_req($sformatf("sv_req%0d", t));
      chk($sformatf("sv_addr%0d", t), 64'(mem_addr), 64'(exp_addr[t]));
      if (!is_cpu && next_push < 8) begin
        rnd_req = 1'b1; rnd_layer = 2'(next_push % 3); rnd_addr = 21'(32'h200 + next_push);
        tick();
        rnd_req = 1'b0;
        next_push++;
      end
      mem_ack = 1'b1;
      mem_data = is_cpu ? 32'h11223344 : 32'(32'hA0000000 + ri);
      tick();
      mem_ack = 1'b0;
      if (is_cpu) begin
        chk("sv_cpu_ack", 64'(cpu_ack), 64'd1);
        chk("sv_cpu_data", 64'(cpu_data), 64'h33);
        chk("sv_cpu_vld", 64'(data_vld), 64'd0);
      end else begin
        chk($sformatf("sv_vld%0d", t), 64'(data_vld), 64'(3'b001 << (ri % 3)));
        chk($sformatf("sv_noack%0d", t), 64'(cpu_ack), 64'd0);
      end
    end
    grants = 0;
    repeat (4) begin
      tick();
      if (mem_req) grants++;
    end
    chk("sv_no_regrant", 64'(grants), 64'd0);
    chk("sv_fix", 64'(fix_data), 64'hA0000006);
    chk("sv_a",   64'(a_data),   64'hA0000007);
    chk("sv_b",   64'(b_data),   64'hA0000005);
    chk("sv_ovf", 64'(ovf), 64'd0);
    cpu_req = 1'b0;
    tick();

    // Layer 3 request is dropped silently
    rnd_req = 1'b1; rnd_layer = 2'd3; rnd_addr = 21'h00055;
    tick();
    rnd_req = 1'b0;
    grants = 0;
    repeat (5) begin
      tick();
      if (mem_req) grants++;
    end
    chk("l3_no_access", 64'(grants), 64'd0);
    chk("l3_ovf", 64'(ovf), 64'd0);

    // Overflow with mem_ack withheld
    for (int k = 0; k < 4; k++) begin
      rnd_req = 1'b1; rnd_layer = 2'd2; rnd_addr = 21'(32'h300 + k);
      tick();
      if (k == 2) chk("of_pre", 64'(ovf), 64'd0);
    end
    rnd_req = 1'b0;
    chk("of_set", 64'(ovf), 64'd1);
    chk("of_head", 64'(mem_addr), 64'h300);
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      wait_req($sformatf("of_req%0d", k));
      chk($sformatf("of_addr%0d", k), 64'(mem_addr), 64'(32'h300 + k));
      mem_ack = 1'b1; mem_data = 32'(32'hB0 + k);
      tick();
      mem_ack = 1'b0;
      chk($sformatf("of_b%0d", k), 64'(b_data), 64'(32'hB0 + k));
    end
    grants = 0;
    repeat (6) begin
      tick();
      if (mem_req) grants++;
    end
    chk("of_dropped", 64'(grants), 64'd0);
    chk("of_sticky", 64'(ovf), 64'd1);

    // Reset in the middle of a render transaction
    rnd_req = 1'b1; rnd_layer = 2'd0; rnd_addr = 21'h00077;
    tick();
    rnd_req = 1'b0;
    wait_req("mr_req");
    chk("mr_addr", 64'(mem_addr), 64'h77);
    #2 nRES = 1'b0;
    #1;
    chk("mr_mem_req", 64'(mem_req), 64'd0);
    chk("mr_mem_addr", 64'(mem_addr), 64'd0);
    chk("mr_ovf", 64'(ovf), 64'd0);
    chk("mr_b_data", 64'(b_data), 64'd0);
    chk("mr_cpu_data", 64'(cpu_data), 64'd0);
    tick();
    nRES = 1'b1;
    mem_ack = 1'b1; mem_data = 32'h12345678;
    tick();
    mem_ack = 1'b0;
    chk("mr_stale_vld", 64'(data_vld), 64'd0);
    chk("mr_stale_ack", 64'(cpu_ack), 64'd0);
    chk("mr_fix_data", 64'(fix_data), 64'd0);
    tick();
    chk("mr_idle", 64'(mem_req), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gfx_rom_sched.md
Name: gfx_rom_sched

Overview:
Schedules a single shared GFX ROM memory port (SDRAM-backed on MiSTer) between two requesters: the plane renderer (fix/A/B tile-line fetches derived from the plane address generator's VC/CAB output) and the CPU ROM-read path (CRCS with RMRD). Render fetches have priority, and a bounded-wait rule stops them from starving the CPU. The block sits between the plane address generator / k051962 pair and the SDRAM controller, and buffers returned tile data per layer.

Parameters:
AW, 21, memory word address width
DW, 32, memory data width (one 8-pixel 4bpp tile line)
CPU_MAX_WAIT, 4, render grants allowed while a CPU request is pending before the CPU is forced in
RQ_DEPTH, 2, render request FIFO depth (power of 2)

Ports:
clk_24M  in  1  system clock
nRES  in  1  asynchronous active-low reset
rnd_req  in  1  one-cycle pulse: render fetch request
rnd_layer  in  2  0=fix, 1=A, 2=B; 3 is ignored (request dropped, ovf not set)
rnd_addr  in  AW  render word address {CAB,VC,...}
cpu_req  in  1  level: CPU ROM read pending; held until cpu_ack
cpu_addr  in  AW+2  CPU byte address; [1:0] selects the byte lane
cpu_ack  out  1  one-cycle pulse when cpu_data is valid
cpu_data  out  8  selected byte; held until the next cpu_ack
mem_req  out  1  memory request, held high until mem_ack
mem_addr  out  AW  memory address, stable while mem_req=1
mem_ack  in  1  one-cycle pulse: mem_data valid
mem_data  in  DW  memory read data
fix_data, a_data, b_data  out  DW  last returned line per layer
data_vld  out  3  one-cycle pulse per layer {B,A,fix} when its register updates
ovf  out  1  sticky: render request lost because the FIFO was full

Behaviour:
- Reset (async, nRES=0): FSM=IDLE; FIFO empty; wait counter=0; mem_req=0, mem_addr=0; cpu_ack=0, cpu_data=0; all layer data regs=0; data_vld=0; ovf=0. An in-flight memory transaction is abandoned, and a mem_ack arriving after reset release while in IDLE is ignored.
- Render FIFO: each rnd_req pushes {layer,addr} on the same edge. If the FIFO is full, the request is discarded and ovf is set; ovf clears only on reset. A push and a pop in the same cycle when full succeed without loss.
- FSM states: IDLE, RND, CPU.
- IDLE -> CPU when cpu_req=1 and cpu_pend_served=0 and (FIFO empty or waitcnt==CPU_MAX_WAIT).
- Otherwise IDLE -> RND when the FIFO is not empty. Pop the head, drive mem_addr, set mem_req on the next edge. If cpu_req=1, waitcnt++ (saturating).
- RND: on mem_ack, write the layer register selected by the popped layer, pulse the matching data_vld bit for 1 cycle, drop mem_req, go to IDLE.
- CPU: mem_addr=cpu_addr[AW+1:2]. On mem_ack, cpu_data = byte cpu_addr[1:0] (0 = bits 7:0 … 3 = bits 31:24); pulse cpu_ack; set cpu_pend_served; waitcnt=0; drop mem_req; go to IDLE.
- cpu_pend_served clears when cpu_req falls. This prevents a re-grant while the CPU is still holding cpu_req after its ack.
- Back-to-back: the minimum gap between mem_req deassert and the next assert is 1 cycle (IDLE is always visited).
- Latency: a render request into an empty FIFO with the FSM in IDLE raises mem_req 2 cycles after rnd_req, then waits on mem_ack.
- mem_addr and the request source never change while mem_req=1.
- cpu_req dropping during CPU state does not abort the transaction; cpu_ack still pulses.

Optional Feature:
SCHED_STATS_EN:
- Defined: adds output stat_maxwait[7:0], the largest number of clk_24M cycles between a cpu_req rise and its cpu_ack since reset (saturating at 255, cleared by nRES).
- Undefined: port absent, no counter logic.

Test Plan:
- Single render: rnd_req layer=1 addr=0x00123, mem_ack 3 cycles after mem_req with data 0xDEADBEEF -> mem_addr=0x00123, a_data=0xDEADBEEF, data_vld=3'b010 for 1 cycle, ovf=0.
- CPU byte read: cpu_req cpu_addr=0x000406, FIFO empty, mem_data=0x44332211 -> mem_addr=0x000101, cpu_data=0x33, one cpu_ack, no re-grant while cpu_req is held.
- Starvation bound: CPU_MAX_WAIT=4, cpu_req high, 8 renders queued continuously -> exactly 4 render grants, then the CPU grant, then renders resume.
- Overflow: RQ_DEPTH=2, mem_ack withheld, 4 rnd_req pulses -> first served, 2 queued, 4th dropped, ovf=1 sticky until nRES.
- Reset mid-transaction: nRES low while mem_req=1 in RND -> all outputs return to reset values immediately; a stale mem_ack after release produces no data_vld or cpu_ack.
- rnd_layer=3 request -> not queued, no memory access, ovf unchanged.
